data_bus_output_seq: RTL and testbench
======================================

Name: data_bus_output_seq

Overview:
Parametrised, sequential successor to the CPU's combinational data-bus output mux. On a start request it snapshots one of NUM_SRC packed register sources and emits 1..MAX_BYTES bus-wide bytes onto the external data bus, one per accepted bus cycle. Byte order is selectable per transfer: MS-first for stores (STD/STX), LS-first for stack pushes (PC/X). It sits between the register file/ALU and the memory interface, and handles wait states through a ready handshake.

Parameters:
BUS_W, 8, data bus width in bits.
NUM_SRC, 9, number of selectable sources (md, acca, accb, x, cc, pc, ...).
MAX_BYTES, 2, maximum bytes per source word; each source slot is MAX_BYTES*BUS_W bits.
Derived (localparam): SEL_W = max(1,$clog2(NUM_SRC)); LEN_W = $clog2(MAX_BYTES+1); WORD_W = MAX_BYTES*BUS_W.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
src_flat  in  NUM_SRC*WORD_W  packed sources; source k = src_flat[k*WORD_W +: WORD_W]; narrower registers zero-extended by the instantiator
src_sel  in  SEL_W  source index, sampled on accepted start
len  in  LEN_W  bytes to emit, sampled on accepted start
order  in  1  0 = MS byte first, 1 = LS byte first; sampled on accepted start
start  in  1  transfer request
mem_ready  in  1  bus accepts the presented byte this cycle
data_out  out  BUS_W  byte presented to the bus (registered)
data_valid  out  1  data_out is valid
byte_idx  out  LEN_W  position of the current byte in transfer order (0 = first)
busy  out  1  transfer in progress
done  out  1  one-cycle pulse after the final byte is accepted

Behaviour:
- Reset, async and active-high: state=IDLE; data_out=0, data_valid=0, byte_idx=0, busy=0, done=0. Reset asserted mid-transfer aborts it. No done pulse follows, and no further bytes are emitted.
- FSM states: IDLE, SEND.
- IDLE:
  - start=1 with len!=0 is accepted. The module latches word=source[src_sel], eff_len=min(len,MAX_BYTES), and order. Next state is SEND.
  - In the following cycle: busy=1, data_valid=1, byte_idx=0, data_out=first byte.
  - Latency from start to first valid byte is 1 cycle.
- start with len=0 in IDLE is ignored: no busy, no done.
- src_sel >= NUM_SRC: the latched word is all zeros. The transfer still runs eff_len bytes of 0x00.
- Byte selection for transfer position i (0..eff_len-1):
  - order=0: word byte (eff_len-1-i).
  - order=1: word byte i.
  - Byte j = word[j*BUS_W +: BUS_W]. Only the low eff_len bytes of the source are used.
- Snapshot rule: source or src_sel changes after acceptance do not affect the bytes emitted.
- SEND, mem_ready=0: data_out, byte_idx and data_valid hold stable. Stalls may be indefinite.
- SEND, mem_ready=1 and byte_idx<eff_len-1: byte_idx increments, and data_out updates to the next byte the following cycle.
- SEND, mem_ready=1 on the last byte: next cycle state=IDLE, busy=0, data_valid=0, data_out=0, done=1 for exactly one cycle.
- Start accepted in the done cycle (back-to-back) is legal. Its first byte appears the cycle after, so there is one dead bus cycle between transfers.
- start while busy=1 is ignored. It is not queued.
- data_out=0 whenever data_valid=0.

Test Plan:
- Defaults; source 5=0x1234; start, sel=5, len=2, order=0, mem_ready=1 -> cycle+1: 0x12 idx0; cycle+2: 0x34 idx1; cycle+3: done=1, busy=0.
- Same stimulus with order=1 (push) -> 0x34 then 0x12, then done.
- len=1, sel=1 (acca slot=0x00A5), order=0 -> single byte 0xA5, then done. Repeat with len=3 -> clamped, 0x00 then 0xA5 (MS-first of 2 bytes).
- mem_ready low for 3 cycles on byte 0 of 0xBEEF -> 0xBE held with idx0 for 4 cycles. Change source 5 to 0x0000 during the stall -> next byte is still 0xEF.
- start in the done cycle with sel=7 (0xC0DE) -> one dead cycle, then 0xC0, 0xDE. Also: start while busy is ignored; len=0 produces no activity; sel=12 produces 0x00, 0x00.
- Assert rst asynchronously after byte 0 of a 2-byte transfer -> all outputs 0 immediately. No done pulse. A new start after release behaves normally.

Source files
------------

// File: rtl/data_bus_output_seq.sv
// Sequential data-bus output stage: snapshots one packed register source on a
// start request and emits it one bus-wide byte per accepted bus cycle,
// MS-first for stores or LS-first for stack pushes, with mem_ready wait states.
//
// state | meaning
// IDLE  | no transfer; outputs quiet, start with nonzero len is accepted
// SEND  | presenting byte byte_idx of the latched word until mem_ready
module data_bus_output_seq #(
   parameter int BUS_W     = 8,
   parameter int NUM_SRC   = 9,
   parameter int MAX_BYTES = 2,
   localparam int SEL_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
   localparam int LEN_W    = $clog2(MAX_BYTES + 1),
   localparam int WORD_W   = MAX_BYTES * BUS_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC*WORD_W-1:0] src_flat,
   input  logic [SEL_W-1:0]          src_sel,
   input  logic [LEN_W-1:0]          len,
   input  logic                      order,
   input  logic                      start,
   input  logic                      mem_ready,
   output logic [BUS_W-1:0]          data_out,
   output logic                      data_valid,
   output logic [LEN_W-1:0]          byte_idx,
   output logic                      busy,
   output logic                      done
);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t             state_q, state_d;
   logic [WORD_W-1:0]  word_q, word_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               order_q, order_d;
   logic [LEN_W-1:0]   idx_q, idx_d;
   logic               done_q, done_d;
   logic [BUS_W-1:0]   dout_q, dout_d;

   logic [WORD_W-1:0]  sel_word;
   logic [LEN_W-1:0]   eff_len;

   // Byte at transfer position pos; order picks which end of the word goes first.
   function automatic logic [BUS_W-1:0] pick_byte(input logic [WORD_W-1:0] w,
                                                  input logic [LEN_W-1:0]  n,
                                                  input logic              ord,
                                                  input logic [LEN_W-1:0]  pos);
      logic [LEN_W-1:0] j;
      logic [BUS_W-1:0] b_out;
      b_out = '0;
      j = ord ? pos : (n - pos - LEN_W'(1));
      for (int b = 0; b < MAX_BYTES; b++) begin
         if (j == LEN_W'(b)) b_out = w[b*BUS_W +: BUS_W];
      end
      return b_out;
   endfunction

   // Source mux; an out-of-range select yields an all-zero word.
   always_comb begin
      sel_word = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (src_sel == SEL_W'(k)) sel_word = src_flat[k*WORD_W +: WORD_W];
      end
      eff_len = (len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : len;
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         word_q  <= '0;
         len_q   <= '0;
         order_q <= 1'b0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         len_q   <= len_d;
         order_q <= order_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         dout_q  <= dout_d;
      end
   end

   // Next-state logic: accept in IDLE, advance on mem_ready in SEND.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      len_d   = len_q;
      order_d = order_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      dout_d  = dout_q;
      case (state_q)
         IDLE: begin
            idx_d  = '0;
            dout_d = '0;
            if (start && (len != '0)) begin
               state_d = SEND;
               word_d  = sel_word;
               len_d   = eff_len;
               order_d = order;
               dout_d  = pick_byte(sel_word, eff_len, order, '0);
            end
         end
         SEND: begin
            if (mem_ready) begin
               if (idx_q == (len_q - LEN_W'(1))) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  idx_d   = '0;
                  dout_d  = '0;
               end else begin
                  idx_d  = idx_q + LEN_W'(1);
                  dout_d = pick_byte(word_q, len_q, order_q, idx_q + LEN_W'(1));
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs come straight from registers.
   always_comb begin
      data_out   = dout_q;
      data_valid = (state_q == SEND);
      busy       = (state_q == SEND);
      byte_idx   = idx_q;
      done       = done_q;
   end

endmodule

// File: tb/tb_data_bus_output_seq.sv
// Randomised self-checking bench for data_bus_output_seq with a queue-based
// reference model of the byte stream each transfer should produce.
module tb_data_bus_output_seq;

   localparam int NSRC = 9;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   src [NSRC];
   logic [NSRC*16-1:0] src_flat;
   logic [3:0]    src_sel = '0;
   logic [1:0]    len = '0;
   logic          order = 1'b0;
   logic          start = 1'b0;
   logic          mem_ready = 1'b0;
   logic [7:0]    data_out;
   logic          data_valid;
   logic [1:0]    byte_idx;
   logic          busy;
   logic          done;

   int n_vec = 0;
   int n_err = 0;
   int exp_q[$];

   data_bus_output_seq dut (
      .clk(clk), .rst(rst), .src_flat(src_flat), .src_sel(src_sel), .len(len),
      .order(order), .start(start), .mem_ready(mem_ready), .data_out(data_out),
      .data_valid(data_valid), .byte_idx(byte_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < NSRC; k++) src_flat[k*16 +: 16] = src[k];
   end

   // {data_valid, busy, done, byte_idx, data_out}
   function automatic logic [12:0] obs();
      return {data_valid, busy, done, byte_idx, data_out};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: expected byte stream from the source value at acceptance time.
   task automatic start_xfer(input int sel, input int ln, input bit ord);
      int eff, w, j;
      eff = (ln > 2) ? 2 : ln;
      w = 0;
      if (sel < NSRC) w = int'(src[sel]);
      exp_q.delete();
      for (int i = 0; i < eff; i++) begin
         j = ord ? i : (eff - 1 - i);
         exp_q.push_back((w >> (8 * j)) & 'hFF);
      end
      src_sel = 4'(sel);
      len     = 2'(ln);
      order   = ord;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   // Walks the expected bytes with stalls, ends in the done cycle.
   task automatic run_bytes(input string name, input int stall_first,
                            input int max_stall, input bit noise);
      logic [12:0] expv;
      int ns;
      for (int i = 0; i < exp_q.size(); i++) begin
         ns = (i == 0) ? stall_first : int'($urandom_range(0, max_stall));
         for (int s = 0; s <= ns; s++) begin
            mem_ready = (s == ns);
            if (noise) begin
               start   = 1'($urandom);
               src_sel = 4'($urandom);
               len     = 2'($urandom_range(1, 3));
               order   = 1'($urandom);
               src[5]  = 16'h0000;
               src[$urandom_range(0, NSRC - 1)] = 16'($urandom);
            end
            expv = {1'b1, 1'b1, 1'b0, 2'(i), 8'(exp_q[i])};
            if (obs() !== expv) begin
               $display("FAIL %s byte %0d stall %0d: got %h want %h", name, i, s, obs(), expv);
               n_err++;
            end
            n_vec++;
            tick();
         end
      end
      start     = 1'b0;
      mem_ready = 1'($urandom);
      expv = {1'b0, 1'b0, 1'b1, 2'd0, 8'h00};
      if (obs() !== expv) begin
         $display("FAIL %s done: got %h want %h", name, obs(), expv);
         n_err++;
      end
      n_vec++;
   endtask

   task automatic finish_idle(input string name);
      tick();
      if (obs() !== 13'h0) begin
         $display("FAIL %s idle: got %h want %h", name, obs(), 13'h0);
         n_err++;
      end
      n_vec++;
   endtask

   task automatic test_reset();
      @(posedge clk);
      #3;
      if (obs() !== 13'h0) begin
         $display("FAIL reset_state: got %h want %h", obs(), 13'h0);
         n_err++;
      end
      n_vec++;
      tick();
      rst = 1'b0;
      tick();
      if (obs() !== 13'h0) begin
         $display("FAIL reset_release: got %h want %h", obs(), 13'h0);
         n_err++;
      end
      n_vec++;
   endtask

   task automatic test_order();
      src[5] = 16'h1234;
      mem_ready = 1'b1;
      start_xfer(5, 2, 1'b0);
      run_bytes("ms_first", 0, 0, 1'b0);
      finish_idle("ms_first");
      src[5] = 16'h1234;
      start_xfer(5, 2, 1'b1);
      run_bytes("ls_first", 0, 0, 1'b0);
      finish_idle("ls_first");
   endtask

   task automatic test_len();
      src[1] = 16'h00A5;
      start_xfer(1, 1, 1'b0);
      run_bytes("len1", 0, 0, 1'b0);
      finish_idle("len1");
      start_xfer(1, 3, 1'b0);
      run_bytes("len3_clamp", 0, 0, 1'b0);
      finish_idle("len3_clamp");
      src_sel = 4'd5;
      len     = 2'd0;
      start   = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         if (obs() !== 13'h0) begin
            $display("FAIL len0 cycle %0d: got %h want %h", c, obs(), 13'h0);
            n_err++;
         end
         n_vec++;
      end
      start = 1'b0;
   endtask

   task automatic test_stall_snapshot();
      src[5] = 16'hBEEF;
      start_xfer(5, 2, 1'b0);
      run_bytes("stall_snapshot", 3, 2, 1'b1);
      finish_idle("stall_snapshot");
   endtask

   task automatic test_back_to_back();
      src[5] = 16'h1234;
      src[7] = 16'hC0DE;
      start_xfer(5, 2, 1'b0);
      run_bytes("b2b_first", 0, 0, 1'b0);
      start_xfer(7, 2, 1'b0);
      run_bytes("b2b_second", 0, 0, 1'b0);
      finish_idle("b2b_second");
   endtask

   task automatic test_bad_sel();
      for (int k = 0; k < NSRC; k++) src[k] = 16'hFFFF;
      start_xfer(12, 2, 1'b0);
      run_bytes("bad_sel", 1, 1, 1'b0);
      finish_idle("bad_sel");
   endtask

   task automatic test_async_reset();
      logic [12:0] expv;
      src[5] = 16'h1234;
      mem_ready = 1'b1;
      start_xfer(5, 2, 1'b0);
      expv = {1'b1, 1'b1, 1'b0, 2'd0, 8'h12};
      if (obs() !== expv) begin
         $display("FAIL areset_pre: got %h want %h", obs(), expv);
         n_err++;
      end
      n_vec++;
      #2 rst = 1'b1;
      #1;
      if (obs() !== 13'h0) begin
         $display("FAIL areset_immediate: got %h want %h", obs(), 13'h0);
         n_err++;
      end
      n_vec++;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
         tick();
         if (obs() !== 13'h0) begin
            $display("FAIL areset_after cycle %0d: got %h want %h", c, obs(), 13'h0);
            n_err++;
         end
         n_vec++;
      end
      src[5] = 16'h1234;
      start_xfer(5, 2, 1'b1);
      run_bytes("areset_restart", 0, 1, 1'b0);
      finish_idle("areset_restart");
   endtask

   task automatic test_random();
      bit chained;
      chained = 1'b0;
      for (int t = 0; t < 40; t++) begin
         if (!chained) begin
            for (int k = 0; k < NSRC; k++) src[k] = 16'($urandom);
         end
         start_xfer(int'($urandom_range(0, 15)), int'($urandom_range(1, 3)), 1'($urandom));
         run_bytes("random", int'($urandom_range(0, 3)), 3, 1'b1);
         chained = 1'($urandom);
         if (!chained) finish_idle("random");
      end
      if (chained) finish_idle("random_tail");
   endtask

   initial begin
      for (int k = 0; k < NSRC; k++) src[k] = 16'(16'h1111 * k);
      test_reset();
      test_order();
      test_len();
      test_stall_snapshot();
      test_back_to_back();
      test_bad_sel();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
